// File: rtl/nested_ifs_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// nested_ifs_cfg_ctrl
//
// Configuration and packet-issue controller for the nested_ifs stateful atom.
// A word-write port fills a shadow copy of the atom configuration. A commit
// request stalls packet issue and waits for the atom pipeline to drain. The
// shadow copy is then transferred to the active copy in a single cycle, so the
// atom never sees a half-updated configuration.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   i__cfg_valid / o__cfg_ready  config word write handshake
//   i__cfg_addr, i__cfg_data     0..10 cons_1..cons_11, 11 sel word A,
//                                12 sel word B, 13..15 illegal
//   i__cfg_commit                request to activate the shadow config
//   o__commit_done               one-cycle pulse when the active config changes
//   o__cfg_err                   sticky flag for writes to illegal addresses
//   i__pkt_valid / o__pkt_ready  packet handshake from the parser
//   i__pkt_1, i__pkt_2           packet fields in
//   o__pkt_1, o__pkt_2           registered packet fields to the atom
//   o__pkt_issue                 o__pkt_* carry a newly accepted packet
//   o__cons                      active cons_1..cons_11 (cons_1 at [31:0])
//   o__sel_mux                   active 2-bit selects (first at [1:0])
//   o__sel_bool                  active 1-bit selects (sel_1 at [0])
//   o__rel_op                    active rel_op1..3 (rel_op1 at [1:0])
//   o__arith_op                  active arith_op1..4 (arith_op1 at [0])
//   o__pkt_count                 packets accepted since reset (wraps)
// -----------------------------------------------------------------------------
module nested_ifs_cfg_ctrl #(
   parameter int PIPE_DEPTH = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i__cfg_valid,
   output logic             o__cfg_ready,
   input  logic [3:0]       i__cfg_addr,
   input  logic [31:0]      i__cfg_data,
   input  logic             i__cfg_commit,
   output logic             o__commit_done,
   output logic             o__cfg_err,
   input  logic             i__pkt_valid,
   output logic             o__pkt_ready,
   input  logic [31:0]      i__pkt_1,
   input  logic [31:0]      i__pkt_2,
   output logic [31:0]      o__pkt_1,
   output logic [31:0]      o__pkt_2,
   output logic             o__pkt_issue,
   output logic [351:0]     o__cons,
   output logic [27:0]      o__sel_mux,
   output logic [6:0]       o__sel_bool,
   output logic [5:0]       o__rel_op,
   output logic [3:0]       o__arith_op,
   output logic [CNT_W-1:0] o__pkt_count
);

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

   localparam int                DRAIN_W    = (PIPE_DEPTH < 2) ? 1 : $clog2(PIPE_DEPTH + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH);

   logic [1:0]         state_q, state_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

   logic [10:0][31:0]  sh_cons_q, sh_cons_d, act_cons_q, act_cons_d;
   logic [27:0]        sh_mux_q, sh_mux_d, act_mux_q, act_mux_d;
   logic [6:0]         sh_bool_q, sh_bool_d, act_bool_q, act_bool_d;
   logic [5:0]         sh_rel_q, sh_rel_d, act_rel_q, act_rel_d;
   logic [3:0]         sh_arith_q, sh_arith_d, act_arith_q, act_arith_d;

   logic               cfg_err_q, cfg_err_d;
   logic               commit_done_q, commit_done_d;
   logic [31:0]        pkt_1_q, pkt_1_d, pkt_2_q, pkt_2_d;
   logic               pkt_issue_q, pkt_issue_d;
   logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

   logic               cfg_ready, pkt_ready, cfg_wr, pkt_acc;

   // Both ready signals depend on state only, never on the matching valid.
   // Config writes are refused only in the single cycle where shadow is copied.
   assign cfg_ready = (state_q != ST_COMMIT);
   assign pkt_ready = (state_q == ST_RUN);
   assign cfg_wr    = i__cfg_valid & cfg_ready;
   assign pkt_acc   = i__pkt_valid & pkt_ready;

   // Shadow config write decode and sticky illegal-address flag.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first; a path that leaves one unassigned would infer a latch.
      sh_cons_d  = sh_cons_q;
      sh_mux_d   = sh_mux_q;
      sh_bool_d  = sh_bool_q;
      sh_rel_d   = sh_rel_q;
      sh_arith_d = sh_arith_q;
      cfg_err_d  = cfg_err_q;
      if (cfg_wr) begin
         case (i__cfg_addr)
            4'd11: sh_mux_d = i__cfg_data[27:0];
            4'd12: begin
               sh_bool_d  = i__cfg_data[6:0];
               sh_rel_d   = i__cfg_data[12:7];
               sh_arith_d = i__cfg_data[16:13];
            end
            4'd13, 4'd14, 4'd15: cfg_err_d = 1'b1;
            default: sh_cons_d[i__cfg_addr] = i__cfg_data;
         endcase
      end
   end

   // Packet issue: one-cycle latency, fields hold between packets.
   always_comb begin
      pkt_1_d     = pkt_1_q;
      pkt_2_d     = pkt_2_q;
      pkt_issue_d = 1'b0;
      pkt_count_d = pkt_count_q;
      if (pkt_acc) begin
         pkt_1_d     = i__pkt_1;
         pkt_2_d     = i__pkt_2;
         pkt_issue_d = 1'b1;
         pkt_count_d = pkt_count_q + CNT_W'(1);
      end
   end

   // Commit sequencing. A commit seen in RUN or EMPTY starts the drain. A
   // packet accepted in that same cycle is already in the pipeline, and the
   // drain covers it. Commits arriving in DRAIN or COMMIT are dropped.
   always_comb begin
      state_d       = state_q;
      drain_cnt_d   = drain_cnt_q;
      act_cons_d    = act_cons_q;
      act_mux_d     = act_mux_q;
      act_bool_d    = act_bool_q;
      act_rel_d     = act_rel_q;
      act_arith_d   = act_arith_q;
      commit_done_d = 1'b0;
      case (state_q)
         ST_EMPTY, ST_RUN: begin
            if (i__cfg_commit) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
            if (drain_cnt_q <= DRAIN_W'(1)) begin
               state_d = ST_COMMIT;
            end
         end
         default: begin
            // Active config and the done pulse become visible together on
            // the first RUN cycle.
            act_cons_d    = sh_cons_q;
            act_mux_d     = sh_mux_q;
            act_bool_d    = sh_bool_q;
            act_rel_d     = sh_rel_q;
            act_arith_d   = sh_arith_q;
            commit_done_d = 1'b1;
            drain_cnt_d   = '0;
            state_d       = ST_RUN;
         end
      endcase
   end

   // NOTE: the config register banks are reset along with the control state.
   // They are ordinary flops, not RAM, and a reset must zero every config
   // output the atom sees.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_EMPTY;
         drain_cnt_q   <= '0;
         sh_cons_q     <= '0;
         sh_mux_q      <= '0;
         sh_bool_q     <= '0;
         sh_rel_q      <= '0;
         sh_arith_q    <= '0;
         act_cons_q    <= '0;
         act_mux_q     <= '0;
         act_bool_q    <= '0;
         act_rel_q     <= '0;
         act_arith_q   <= '0;
         cfg_err_q     <= 1'b0;
         commit_done_q <= 1'b0;
         pkt_1_q       <= '0;
         pkt_2_q       <= '0;
         pkt_issue_q   <= 1'b0;
         pkt_count_q   <= '0;
      end else begin
         // NOTE: flops update with non-blocking assignments so that every
         // flop samples the pre-edge values of the others.
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         sh_cons_q     <= sh_cons_d;
         sh_mux_q      <= sh_mux_d;
         sh_bool_q     <= sh_bool_d;
         sh_rel_q      <= sh_rel_d;
         sh_arith_q    <= sh_arith_d;
         act_cons_q    <= act_cons_d;
         act_mux_q     <= act_mux_d;
         act_bool_q    <= act_bool_d;
         act_rel_q     <= act_rel_d;
         act_arith_q   <= act_arith_d;
         cfg_err_q     <= cfg_err_d;
         commit_done_q <= commit_done_d;
         pkt_1_q       <= pkt_1_d;
         pkt_2_q       <= pkt_2_d;
         pkt_issue_q   <= pkt_issue_d;
         pkt_count_q   <= pkt_count_d;
      end
   end

   assign o__cfg_ready   = cfg_ready;
   assign o__pkt_ready   = pkt_ready;
   assign o__commit_done = commit_done_q;
   assign o__cfg_err     = cfg_err_q;
   assign o__pkt_1       = pkt_1_q;
   assign o__pkt_2       = pkt_2_q;
   assign o__pkt_issue   = pkt_issue_q;
   assign o__cons        = act_cons_q;
   assign o__sel_mux     = act_mux_q;
   assign o__sel_bool    = act_bool_q;
   assign o__rel_op      = act_rel_q;
   assign o__arith_op    = act_arith_q;
   assign o__pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_nested_ifs_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nested_ifs_cfg_ctrl
//
// Self-checking bench for nested_ifs_cfg_ctrl. A behavioural model treats a
// commit as a stall window of PIPE_DEPTH+1 cycles, and the shadow copy is
// applied when that window closes. The model is compared against two
// instances on every cycle. One instance uses the full 32-bit counter. The
// other uses a 3-bit counter, so counter wrap is observed often. Directed
// scenarios with literal expectations run first, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_nested_ifs_cfg_ctrl;

   localparam int PIPE_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cfg_valid, i_cfg_commit, i_pkt_valid;
   logic [3:0]  i_cfg_addr;
   logic [31:0] i_cfg_data, i_pkt_1, i_pkt_2;

   logic         o_cfg_ready, o_commit_done, o_cfg_err, o_pkt_ready, o_pkt_issue;
   logic [31:0]  o_pkt_1, o_pkt_2, o_pkt_count;
   logic [351:0] o_cons;
   logic [27:0]  o_sel_mux;
   logic [6:0]   o_sel_bool;
   logic [5:0]   o_rel_op;
   logic [3:0]   o_arith_op;

   logic         s_cfg_ready, s_commit_done, s_cfg_err, s_pkt_ready, s_pkt_issue;
   logic [31:0]  s_pkt_1, s_pkt_2;
   logic [2:0]   s_pkt_count;
   logic [351:0] s_cons;
   logic [27:0]  s_sel_mux;
   logic [6:0]   s_sel_bool;
   logic [5:0]   s_rel_op;
   logic [3:0]   s_arith_op;

   always #5 clk = ~clk;

   nested_ifs_cfg_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .i__cfg_valid(i_cfg_valid), .o__cfg_ready(o_cfg_ready),
      .i__cfg_addr(i_cfg_addr), .i__cfg_data(i_cfg_data),
      .i__cfg_commit(i_cfg_commit), .o__commit_done(o_commit_done),
      .o__cfg_err(o_cfg_err),
      .i__pkt_valid(i_pkt_valid), .o__pkt_ready(o_pkt_ready),
      .i__pkt_1(i_pkt_1), .i__pkt_2(i_pkt_2),
      .o__pkt_1(o_pkt_1), .o__pkt_2(o_pkt_2), .o__pkt_issue(o_pkt_issue),
      .o__cons(o_cons), .o__sel_mux(o_sel_mux), .o__sel_bool(o_sel_bool),
      .o__rel_op(o_rel_op), .o__arith_op(o_arith_op),
      .o__pkt_count(o_pkt_count)
   );

   nested_ifs_cfg_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .CNT_W(3)) dut_wrap (
      .clk(clk), .rst(rst),
      .i__cfg_valid(i_cfg_valid), .o__cfg_ready(s_cfg_ready),
      .i__cfg_addr(i_cfg_addr), .i__cfg_data(i_cfg_data),
      .i__cfg_commit(i_cfg_commit), .o__commit_done(s_commit_done),
      .o__cfg_err(s_cfg_err),
      .i__pkt_valid(i_pkt_valid), .o__pkt_ready(s_pkt_ready),
      .i__pkt_1(i_pkt_1), .i__pkt_2(i_pkt_2),
      .o__pkt_1(s_pkt_1), .o__pkt_2(s_pkt_2), .o__pkt_issue(s_pkt_issue),
      .o__cons(s_cons), .o__sel_mux(s_sel_mux), .o__sel_bool(s_sel_bool),
      .o__rel_op(s_rel_op), .o__arith_op(s_arith_op),
      .o__pkt_count(s_pkt_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_stall;      // remaining cycles with packet issue stalled
   bit          m_running;    // a commit has completed since reset
   logic [31:0] m_sh_cons [11];
   logic [31:0] m_act_cons [11];
   logic [27:0] m_sh_mux, m_act_mux;
   logic [6:0]  m_sh_bool, m_act_bool;
   logic [5:0]  m_sh_rel, m_act_rel;
   logic [3:0]  m_sh_arith, m_act_arith;
   logic        m_err, m_done, m_issue;
   logic [31:0] m_pkt1, m_pkt2, m_count;

   task automatic m_reset();
      m_stall = 0; m_running = 0;
      for (int k = 0; k < 11; k++) begin
         m_sh_cons[k] = '0; m_act_cons[k] = '0;
      end
      m_sh_mux = '0; m_act_mux = '0; m_sh_bool = '0; m_act_bool = '0;
      m_sh_rel = '0; m_act_rel = '0; m_sh_arith = '0; m_act_arith = '0;
      m_err = 0; m_done = 0; m_issue = 0; m_pkt1 = '0; m_pkt2 = '0; m_count = '0;
   endtask

   task automatic m_step();
      bit pkt_ok, cfg_ok;
      pkt_ok = m_running && (m_stall == 0);
      cfg_ok = (m_stall != 1);
      m_issue = 0;
      m_done  = 0;
      if (i_pkt_valid && pkt_ok) begin
         m_pkt1 = i_pkt_1; m_pkt2 = i_pkt_2; m_issue = 1; m_count = m_count + 1;
      end
      if (i_cfg_valid && cfg_ok) begin
         if (i_cfg_addr <= 4'd10) m_sh_cons[i_cfg_addr] = i_cfg_data;
         else if (i_cfg_addr == 4'd11) m_sh_mux = i_cfg_data[27:0];
         else if (i_cfg_addr == 4'd12) begin
            m_sh_bool = i_cfg_data[6:0]; m_sh_rel = i_cfg_data[12:7]; m_sh_arith = i_cfg_data[16:13];
         end else m_err = 1;
      end
      if (m_stall == 0) begin
         if (i_cfg_commit) m_stall = PIPE_DEPTH + 1;
      end else begin
         m_stall--;
         if (m_stall == 0) begin
            for (int k = 0; k < 11; k++) m_act_cons[k] = m_sh_cons[k];
            m_act_mux = m_sh_mux; m_act_bool = m_sh_bool;
            m_act_rel = m_sh_rel; m_act_arith = m_sh_arith;
            m_done = 1; m_running = 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
   end

   function automatic logic [351:0] exp_cons();
      logic [351:0] r;
      for (int k = 0; k < 11; k++) r[32*k +: 32] = m_act_cons[k];
      return r;
   endfunction

   task automatic compare_set(input string p, input logic cfg_rdy, input logic done,
                              input logic err, input logic pkt_rdy, input logic [31:0] p1,
                              input logic [31:0] p2, input logic iss, input logic [351:0] cons,
                              input logic [27:0] mux, input logic [6:0] bl, input logic [5:0] rel,
                              input logic [3:0] ar, input logic [31:0] cnt, input logic [31:0] cnt_mask);
      check({p, "cfg_ready"},   cfg_rdy, m_stall != 1);
      check({p, "pkt_ready"},   pkt_rdy, m_running && (m_stall == 0));
      check({p, "commit_done"}, done, m_done);
      check({p, "cfg_err"},     err, m_err);
      check({p, "pkt_issue"},   iss, m_issue);
      check({p, "pkt_1"},       p1, m_pkt1);
      check({p, "pkt_2"},       p2, m_pkt2);
      check({p, "cons"},        cons, exp_cons());
      check({p, "sel_mux"},     mux, m_act_mux);
      check({p, "sel_bool"},    bl, m_act_bool);
      check({p, "rel_op"},      rel, m_act_rel);
      check({p, "arith_op"},    ar, m_act_arith);
      check({p, "pkt_count"},   cnt, m_count & cnt_mask);
   endtask

   bit cmp_en = 0;
   int done_seen = 0;
   int issue_seen = 0;

   initial forever begin
      @(negedge clk);
      if (o_commit_done) done_seen++;
      if (o_pkt_issue) issue_seen++;
      if (cmp_en) begin
         compare_set("main.", o_cfg_ready, o_commit_done, o_cfg_err, o_pkt_ready, o_pkt_1,
                     o_pkt_2, o_pkt_issue, o_cons, o_sel_mux, o_sel_bool, o_rel_op,
                     o_arith_op, o_pkt_count, 32'hFFFF_FFFF);
         compare_set("wrap.", s_cfg_ready, s_commit_done, s_cfg_err, s_pkt_ready, s_pkt_1,
                     s_pkt_2, s_pkt_issue, s_cons, s_sel_mux, s_sel_bool, s_rel_op,
                     s_arith_op, {29'd0, s_pkt_count}, 32'h7);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      i_cfg_valid = 0; i_cfg_commit = 0; i_pkt_valid = 0;
      i_cfg_addr = '0; i_cfg_data = '0; i_pkt_1 = '0; i_pkt_2 = '0;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      i_cfg_valid = 1; i_cfg_addr = a; i_cfg_data = d;
      tick();
      i_cfg_valid = 0;
   endtask

   // Commit and wait until the first RUN cycle is visible.
   task automatic do_commit();
      i_cfg_commit = 1;
      tick();
      i_cfg_commit = 0;
      repeat (PIPE_DEPTH + 1) tick();
   endtask

   int cnt0, iss0, d0, guard, wait4;

   initial begin
      rst = 1;
      idle();
      // Scenario 1: after reset no packet is accepted, even while valid is held.
      i_pkt_valid = 1;
      repeat (2) tick();
      cmp_en = 1;
      rst = 0;
      repeat (5) tick();
      check("empty_pkt_ready", o_pkt_ready, 1'b0);
      check("empty_count", o_pkt_count, 32'd0);
      check("empty_cons", o_cons, '0);
      i_pkt_valid = 0;

      // Scenario 2: first configuration, EMPTY -> DRAIN x2 -> COMMIT -> RUN.
      cfg_write(4'd0, 32'h5);
      cfg_write(4'd12, 32'h0001_FFFF);
      i_cfg_commit = 1;
      tick();
      i_cfg_commit = 0;
      check("drain1_ready", o_pkt_ready, 1'b0);
      check("drain1_cons", o_cons[31:0], 32'd0);
      tick();
      check("drain2_cons", o_cons[31:0], 32'd0);
      tick();
      check("commit_cfg_ready", o_cfg_ready, 1'b0);
      check("commit_cons", o_cons[31:0], 32'd0);
      tick();
      check("run_cons1", o_cons[31:0], 32'd5);
      check("run_sel_bool", o_sel_bool, 7'h7F);
      check("run_rel_op", o_rel_op, 6'h3F);
      check("run_arith_op", o_arith_op, 4'hF);
      check("run_done_pulse", o_commit_done, 1'b1);
      check("run_pkt_ready", o_pkt_ready, 1'b1);
      tick();
      check("done_single", o_commit_done, 1'b0);

      // Scenario 3: five back-to-back packets with a commit on the third.
      cnt0 = o_pkt_count; iss0 = issue_seen; wait4 = -1;
      for (int k = 1; k <= 5; k++) begin
         i_pkt_valid = 1; i_pkt_1 = k; i_pkt_2 = 32'h100 * k;
         guard = 0;
         while (!o_pkt_ready && guard < 10) begin
            tick();
            guard++;
         end
         check("pkt_ready_bound", guard < 10, 1'b1);
         if (k == 4) wait4 = guard;
         i_cfg_commit = (k == 3);
         tick();
         i_cfg_commit = 0;
      end
      i_pkt_valid = 0;
      tick();
      check("stall_cycles", wait4, PIPE_DEPTH + 1);
      check("stream_count", o_pkt_count - cnt0, 32'd5);
      check("stream_issued", issue_seen - iss0, 5);
      check("stream_last_pkt", o_pkt_1, 32'd5);

      // Scenario 4: illegal address sets a sticky error and leaves shadow alone.
      cfg_write(4'd14, 32'h1234_5678);
      check("err_set", o_cfg_err, 1'b1);
      cfg_write(4'd1, 32'h7);
      do_commit();
      check("err_sticky", o_cfg_err, 1'b1);
      check("cons2_after", o_cons[63:32], 32'h7);
      check("mux_untouched", o_sel_mux, 28'd0);

      // Scenario 5: a shadow write alone never reaches the active config. A
      // write during the drain is included, and a second commit is ignored.
      cfg_write(4'd2, 32'hAA);
      repeat (3) tick();
      check("no_commit_cons3", o_cons[95:64], 32'd0);
      d0 = done_seen;
      i_cfg_commit = 1;
      tick();
      i_cfg_valid = 1; i_cfg_addr = 4'd2; i_cfg_data = 32'hBB; i_cfg_commit = 1;
      tick();
      idle();
      repeat (3) tick();
      check("drain_write_cons3", o_cons[95:64], 32'hBB);
      check("one_done_pulse", done_seen - d0, 1);

      // Scenario 6: reset in the middle of a drain.
      i_cfg_commit = 1;
      tick();
      i_cfg_commit = 0;
      #2 rst = 1;
      #1;
      check("rst_pkt_ready", o_pkt_ready, 1'b0);
      check("rst_cons", o_cons, '0);
      check("rst_sel_bool", o_sel_bool, 7'd0);
      check("rst_err", o_cfg_err, 1'b0);
      check("rst_count", o_pkt_count, 32'd0);
      d0 = done_seen;
      tick();
      tick();
      rst = 0;
      repeat (5) tick();
      check("rst_no_done", done_seen - d0, 0);
      check("rst_still_empty", o_pkt_ready, 1'b0);

      // Counter wrap on the 3-bit instance.
      do_commit();
      i_pkt_valid = 1;
      repeat (8) tick();
      check("wrap_at_8", s_pkt_count, 3'd0);
      check("full_at_8", o_pkt_count, 32'd8);
      tick();
      check("wrap_at_9", s_pkt_count, 3'd1);
      i_pkt_valid = 0;

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         i_pkt_valid  = ($urandom_range(0, 3) != 0);
         i_pkt_1      = $urandom;
         i_pkt_2      = $urandom;
         i_cfg_valid  = ($urandom_range(0, 3) == 0);
         i_cfg_addr   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 12));
         i_cfg_data   = $urandom;
         i_cfg_commit = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1;
            tick();
            rst = 0;
         end else begin
            tick();
         end
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
